// File: rtl/riscv_defines.sv
// Shared types and helpers for the instruction fetch unit.
package riscv_defines;

    localparam int XLEN          = 32;
    localparam int FETCH_ENTRY_W = 2 * XLEN + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RVALID,
        WAIT_ABORTED
    } fetch_state_e;

    typedef struct packed {
        logic            err;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] rdata;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction

    function automatic logic [XLEN-1:0] next_word(input logic [XLEN-1:0] a);
        return a + XLEN'(4);
    endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Small circular buffer of fetched words with their addresses and error flag.
module riscv_fetch_fifo
    import riscv_defines::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [FETCH_ENTRY_W-1:0] entry_i,
    input  logic                     pop_i,
    output logic [FETCH_ENTRY_W-1:0] entry_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [FETCH_ENTRY_W-1:0] mem_q [DEPTH];
    logic [FETCH_ENTRY_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = entry_i;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push_i && !pop_i) begin
                count_d = count_q + CW'(1);
            end else if (!push_i && pop_i) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Storage is cleared so the head outputs read zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign entry_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/riscv_instr_fetch_unit.sv
// Instruction fetch engine: one outstanding bus transaction feeding a small FIFO.
module riscv_instr_fetch_unit
    import riscv_defines::*;
#(
    parameter int DEPTH       = 2,
    parameter int RDATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_i,
    input  logic                   branch_i,
    input  logic [31:0]            addr_i,
    input  logic                   ready_i,
    output logic                   valid_o,
    output logic [31:0]            rdata_o,
    output logic [31:0]            addr_o,
    output logic                   fetch_failed_o,
    output logic                   instr_req_o,
    output logic [31:0]            instr_addr_o,
    input  logic                   instr_gnt_i,
    input  logic                   instr_rvalid_i,
    input  logic [RDATA_WIDTH-1:0] instr_rdata_i,
    input  logic                   instr_err_pmp_i,
    output logic                   busy_o
);

    localparam int             CW        = $clog2(DEPTH) + 1;
    localparam logic [CW:0]    DEPTH_OCC = (CW + 1)'(DEPTH);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_addr_q, fetch_addr_d;
    logic [31:0]  rsp_addr_q, rsp_addr_d;
    logic         err_lock_q, err_lock_d;

    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          issue;
    logic          rsp_ok;
    logic          lock;
    logic          room;
    logic          may_issue;
    logic [CW:0]   occ;
    logic [31:0]   target;
    logic [31:0]   req_addr;

    fetch_entry_t             push_entry;
    fetch_entry_t             head;
    logic [FETCH_ENTRY_W-1:0] head_bits;

    assign target   = word_align(addr_i);
    assign req_addr = branch_i ? target : fetch_addr_q;

    assign valid_o = !empty && !branch_i;
    assign pop     = valid_o && ready_i;

    // A response is kept only when it belongs to the live stream.
    assign rsp_ok = instr_rvalid_i && (state_q == WAIT_RVALID) && !branch_i;
    assign push   = rsp_ok;

    assign lock = !branch_i && (err_lock_q || (rsp_ok && instr_err_pmp_i));

    // Occupancy seen by a newly issued request once this cycle settles.
    always_comb begin
        occ = '0;
        if (!branch_i) begin
            occ = {1'b0, count} + (CW + 1)'(push) - (CW + 1)'(pop);
        end
    end

    assign room      = occ < DEPTH_OCC;
    assign may_issue = req_i && !lock && room && !rst;

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        rsp_addr_d   = rsp_addr_q;
        err_lock_d   = err_lock_q;
        issue        = 1'b0;

        if (branch_i) begin
            fetch_addr_d = target;
            err_lock_d   = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                issue = may_issue;
                if (issue) begin
                    state_d = instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                issue   = !rst;
                state_d = instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
            end
            WAIT_RVALID, WAIT_ABORTED: begin
                if (instr_rvalid_i) begin
                    issue = may_issue;
                    if (!issue) begin
                        state_d = IDLE;
                    end else begin
                        state_d = instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
                    end
                end else if (branch_i) begin
                    state_d = WAIT_ABORTED;
                end
            end
        endcase

        if (issue && instr_gnt_i) begin
            fetch_addr_d = next_word(req_addr);
            rsp_addr_d   = req_addr;
        end

        if (rsp_ok && instr_err_pmp_i) begin
            err_lock_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            fetch_addr_q <= '0;
            rsp_addr_q   <= '0;
            err_lock_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            rsp_addr_q   <= rsp_addr_d;
            err_lock_q   <= err_lock_d;
        end
    end

    always_comb begin
        push_entry       = '0;
        push_entry.err   = instr_err_pmp_i;
        push_entry.addr  = rsp_addr_q;
        push_entry.rdata = instr_rdata_i;
    end

    riscv_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (branch_i),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (pop),
        .entry_o (head_bits),
        .count_o (count),
        .empty_o (empty),
        .full_o  (full)
    );

    // Admission control must make a refused push impossible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full && !pop));
        end
    end

    assign head           = fetch_entry_t'(head_bits);
    assign rdata_o        = head.rdata;
    assign addr_o         = head.addr;
    assign fetch_failed_o = head.err && valid_o;

    assign instr_req_o  = issue;
    assign instr_addr_o = issue ? req_addr : '0;

    assign busy_o = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_riscv_instr_fetch_unit.sv
// Scoreboard bench for riscv_instr_fetch_unit with a simple bus responder.
module tb_riscv_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic        branch_i;
    logic [31:0] addr_i;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] rdata_o;
    logic [31:0] addr_o;
    logic        fetch_failed_o;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_err_pmp_i;
    logic        busy_o;

    always #5 clk = ~clk;

    riscv_instr_fetch_unit #(
        .DEPTH       (2),
        .RDATA_WIDTH (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_i           (req_i),
        .branch_i        (branch_i),
        .addr_i          (addr_i),
        .ready_i         (ready_i),
        .valid_o         (valid_o),
        .rdata_o         (rdata_o),
        .addr_o          (addr_o),
        .fetch_failed_o  (fetch_failed_o),
        .instr_req_o     (instr_req_o),
        .instr_addr_o    (instr_addr_o),
        .instr_gnt_i     (instr_gnt_i),
        .instr_rvalid_i  (instr_rvalid_i),
        .instr_rdata_i   (instr_rdata_i),
        .instr_err_pmp_i (instr_err_pmp_i),
        .busy_o          (busy_o)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_chk = 0;
    int   n_pass = 0;
    int   nreq;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Bus responder: auto mode grants at once and answers ~addr next cycle.
    logic        auto_en = 1'b0;
    logic        man_gnt = 1'b0;
    logic        man_rvalid = 1'b0;
    logic        man_err = 1'b0;
    logic [31:0] man_rdata = '0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    logic        fire;
    logic [31:0] fire_addr;

    assign instr_gnt_i     = auto_en ? instr_req_o : man_gnt;
    assign instr_rvalid_i  = auto_en ? pend : man_rvalid;
    assign instr_rdata_i   = auto_en ? ~pend_addr : man_rdata;
    assign instr_err_pmp_i = auto_en ? (pend && pend_addr == err_addr) : man_err;

    initial forever begin
        @(negedge clk);
        fire      = auto_en && instr_req_o && instr_gnt_i;
        fire_addr = instr_addr_o;
        @(posedge clk);
        #1;
        pend      = fire;
        pend_addr = fire_addr;
    end

    // Monitor: every accepted head entry is compared against the queue.
    initial forever begin
        @(negedge clk);
        if (valid_o && ready_i) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL pop_unexpected: got addr %h, expected no entry", addr_o);
            end else begin
                e = exp_q.pop_front();
                if (addr_o === e.addr && rdata_o === e.data && fetch_failed_o === e.err)
                    n_pass++;
                else
                    $display("FAIL pop: got %h/%h/%b expected %h/%h/%b",
                             addr_o, rdata_o, fetch_failed_o, e.addr, e.data, e.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req_i = 1'b0; branch_i = 1'b0; addr_i = '0; ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_flags", {28'b0, valid_o, fetch_failed_o, instr_req_o, busy_o}, 32'h0);
        chk("rst_addr_o", addr_o, 32'h0);
        chk("rst_rdata_o", rdata_o, 32'h0);
        chk("rst_instr_addr", instr_addr_o, 32'h0);

        // Boot fetch, zero-wait bus
        auto_en = 1'b1;
        exp_q.push_back('{32'h1C00_0080, 32'hE3FF_FF7F, 1'b0});
        exp_q.push_back('{32'h1C00_0084, 32'hE3FF_FF7B, 1'b0});
        exp_q.push_back('{32'h1C00_0088, 32'hE3FF_FF77, 1'b0});
        cyc(); branch_i = 1'b1; addr_i = 32'h1C00_0080; req_i = 1'b1; ready_i = 1'b1;
        @(negedge clk);
        chk("boot_req0", 32'(instr_req_o), 32'h1);
        chk("boot_addr0", instr_addr_o, 32'h1C00_0080);
        cyc(); branch_i = 1'b0;
        @(negedge clk);
        chk("boot_latency", 32'(valid_o), 32'h0);
        chk("boot_addr1", instr_addr_o, 32'h1C00_0084);
        cyc();
        @(negedge clk);
        chk("boot_valid2", 32'(valid_o), 32'h1);
        cyc(); req_i = 1'b0;
        @(negedge clk);
        chk("boot_valid3", 32'(valid_o), 32'h1);
        cyc();
        @(negedge clk);
        chk("boot_valid4", 32'(valid_o), 32'h1);
        cyc();
        @(negedge clk);
        chk("boot_valid5", 32'(valid_o), 32'h0);
        chk("boot_busy", 32'(busy_o), 32'h0);
        chk("boot_drain", exp_q.size(), 32'h0);

        // Backpressure: only DEPTH requests while the IF stage stalls
        exp_q.push_back('{32'h0000_2000, 32'hFFFF_DFFF, 1'b0});
        exp_q.push_back('{32'h0000_2004, 32'hFFFF_DFFB, 1'b0});
        cyc(); branch_i = 1'b1; addr_i = 32'h2000; req_i = 1'b1; ready_i = 1'b0;
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (instr_req_o && instr_gnt_i) nreq++;
            cyc(); branch_i = 1'b0;
        end
        chk("bp_reqs", nreq, 32'd2);
        @(negedge clk);
        chk("bp_req_off", 32'(instr_req_o), 32'h0);
        cyc(); req_i = 1'b0; ready_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            cyc();
        end
        @(negedge clk);
        chk("bp_drain", exp_q.size(), 32'h0);

        // Grant stall then branch while waiting
        cyc(); auto_en = 1'b0;
        exp_q.push_back('{32'h0000_0200, 32'h1111_2222, 1'b0});
        branch_i = 1'b1; addr_i = 32'h100; req_i = 1'b1; man_gnt = 1'b0;
        @(negedge clk);
        chk("stall_addr0", instr_addr_o, 32'h100);
        cyc(); branch_i = 1'b0; req_i = 1'b0;
        @(negedge clk);
        chk("stall_hold1", instr_addr_o, 32'h100);
        cyc();
        @(negedge clk);
        chk("stall_hold2", instr_addr_o, 32'h100);
        cyc(); branch_i = 1'b1; addr_i = 32'h200;
        @(negedge clk);
        chk("stall_branch", instr_addr_o, 32'h200);
        cyc(); branch_i = 1'b0; man_gnt = 1'b1;
        @(negedge clk);
        chk("stall_branch_hold", instr_addr_o, 32'h200);
        cyc(); man_gnt = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h1111_2222;
        @(negedge clk);
        chk("stall_noreq", 32'(instr_req_o), 32'h0);
        cyc(); man_rvalid = 1'b0;
        @(negedge clk);
        cyc();
        @(negedge clk);
        chk("stall_drain", exp_q.size(), 32'h0);

        // Branch while a response is outstanding: that response is dropped
        exp_q.push_back('{32'h0000_0400, 32'hCAFE_0400, 1'b0});
        cyc(); branch_i = 1'b1; addr_i = 32'h104; req_i = 1'b1; man_gnt = 1'b1;
        @(negedge clk);
        chk("abort_addr0", instr_addr_o, 32'h104);
        cyc(); branch_i = 1'b1; addr_i = 32'h400; man_gnt = 1'b0;
        @(negedge clk);
        chk("abort_noreq1", 32'(instr_req_o), 32'h0);
        cyc(); branch_i = 1'b0;
        @(negedge clk);
        chk("abort_noreq2", 32'(instr_req_o), 32'h0);
        cyc(); man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF; man_gnt = 1'b1;
        @(negedge clk);
        chk("abort_issue", instr_addr_o, 32'h400);
        cyc(); man_gnt = 1'b0; man_rdata = 32'hCAFE_0400; req_i = 1'b0;
        @(negedge clk);
        cyc(); man_rvalid = 1'b0;
        @(negedge clk);
        cyc();
        @(negedge clk);
        chk("abort_drain", exp_q.size(), 32'h0);

        // PMP error locks fetching until the next branch
        cyc(); auto_en = 1'b1; err_addr = 32'h300;
        exp_q.push_back('{32'h0000_0600, 32'hFFFF_F9FF, 1'b0});
        branch_i = 1'b1; addr_i = 32'h300; req_i = 1'b1; ready_i = 1'b0;
        @(negedge clk);
        chk("pmp_addr_req", instr_addr_o, 32'h300);
        cyc(); branch_i = 1'b0;
        @(negedge clk);
        chk("pmp_lock0", 32'(instr_req_o), 32'h0);
        cyc();
        @(negedge clk);
        chk("pmp_head_flags", {30'b0, valid_o, fetch_failed_o}, 32'h3);
        chk("pmp_head_addr", addr_o, 32'h300);
        nreq = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            @(negedge clk);
            if (instr_req_o) nreq++;
        end
        chk("pmp_locked", nreq, 32'd0);
        cyc(); branch_i = 1'b1; addr_i = 32'h600; ready_i = 1'b1;
        @(negedge clk);
        chk("pmp_branch_addr", instr_addr_o, 32'h600);
        chk("pmp_branch_fail", 32'(fetch_failed_o), 32'h0);
        cyc(); branch_i = 1'b0; req_i = 1'b0; err_addr = 32'hFFFF_FFFF;
        @(negedge clk);
        cyc();
        @(negedge clk);
        cyc();
        @(negedge clk);
        chk("pmp_drain", exp_q.size(), 32'h0);

        // Address wrap at the top of memory
        exp_q.push_back('{32'hFFFF_FFF8, 32'h0000_0007, 1'b0});
        exp_q.push_back('{32'hFFFF_FFFC, 32'h0000_0003, 1'b0});
        exp_q.push_back('{32'h0000_0000, 32'hFFFF_FFFF, 1'b0});
        cyc(); branch_i = 1'b1; addr_i = 32'hFFFF_FFF8; req_i = 1'b1;
        @(negedge clk);
        cyc(); branch_i = 1'b0;
        @(negedge clk);
        chk("wrap_addr1", instr_addr_o, 32'hFFFF_FFFC);
        cyc();
        @(negedge clk);
        chk("wrap_req2", 32'(instr_req_o), 32'h1);
        cyc(); req_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            cyc();
        end
        @(negedge clk);
        chk("wrap_drain", exp_q.size(), 32'h0);

        // Reset while a response is outstanding; the late response is ignored
        cyc(); auto_en = 1'b0;
        branch_i = 1'b1; addr_i = 32'h500; req_i = 1'b1; man_gnt = 1'b1;
        @(negedge clk);
        chk("rst2_addr", instr_addr_o, 32'h500);
        cyc(); branch_i = 1'b0; req_i = 1'b0; man_gnt = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rst2_busy_before", 32'(busy_o), 32'h1);
        cyc(); rst = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("rst2_flags", {28'b0, valid_o, fetch_failed_o, instr_req_o, busy_o}, 32'h0);
        chk("rst2_addr_o", addr_o, 32'h0);
        chk("rst2_rdata_o", rdata_o, 32'h0);
        chk("rst2_instr_addr", instr_addr_o, 32'h0);
        cyc(); man_rvalid = 1'b0;
        @(negedge clk);
        chk("rst2_after_flags", {28'b0, valid_o, fetch_failed_o, instr_req_o, busy_o}, 32'h0);
        chk("rst2_after_rdata", rdata_o, 32'h0);

        chk("final_drain", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
